// File: rtl/mul_issue_wb.sv
// Issue/writeback control stage around the combinational RV32M multiplier.
// Define MUL_B2B_EN to accept a new op in the same edge a result handshakes.
module mul_issue_wb #(
  parameter int dataW = 32,
  parameter int LAT   = 1,
  parameter int RDW   = 5
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [dataW-1:0] rs1,
  input  logic [dataW-1:0] rs2,
  input  logic [RDW-1:0]   rd,
  output logic [dataW-1:0] mul_M,
  output logic [dataW-1:0] mul_Q,
  output logic [dataW-1:0] mul_UM,
  output logic [dataW-1:0] mul_UQ,
  output logic [1:0]       mul_code,
  input  logic [dataW-1:0] mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [dataW-1:0] out_data,
  output logic [RDW-1:0]   out_rd,
  output logic             out_illegal,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] MULC    = 2'b00;
  localparam logic [1:0] MULHC   = 2'b01;
  localparam logic [1:0] MULHSUC = 2'b10;
  localparam logic [1:0] MULHUC  = 2'b11;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [dataW-1:0] m_q, m_d, q_q, q_d, um_q, um_d, uq_q, uq_d;
  logic [1:0]       code_q, code_d;
  logic             ill_q, ill_d;
  logic [RDW-1:0]   rd_q, rd_d;
  logic [dataW-1:0] out_data_q, out_data_d;
  logic [RDW-1:0]   out_rd_q, out_rd_d;
  logic             out_ill_q, out_ill_d;
  logic             accept_s;

`ifdef MUL_B2B_EN
  assign in_ready = nReset && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
`else
  assign in_ready = nReset && (state_q == S_IDLE);
`endif

  assign accept_s = in_valid && in_ready;

  // Next-state: capture on the last settle cycle, hold in DONE, latch a new op on accept.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_d        = m_q;
    q_d        = q_q;
    um_d       = um_q;
    uq_d       = uq_q;
    code_d     = code_q;
    ill_d      = ill_q;
    rd_d       = rd_q;
    out_data_d = out_data_q;
    out_rd_d   = out_rd_q;
    out_ill_d  = out_ill_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_CALC: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_DONE;
          out_data_d = ill_q ? '0 : mul_result;
          out_rd_d   = rd_q;
          out_ill_d  = ill_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // MULHSU swaps Q/UM so the multiplier's UM*Q yields signed rs1 x unsigned rs2.
    if (accept_s) begin
      state_d = S_CALC;
      cnt_d   = CNT_INIT;
      rd_d    = rd;
      ill_d   = funct3[2];
      m_d     = rs1;
      uq_d    = rs2;
      if (funct3 == 3'b010) begin
        q_d  = rs1;
        um_d = rs2;
      end else begin
        q_d  = rs2;
        um_d = rs1;
      end
      case (funct3)
        3'b000:  code_d = MULC;
        3'b001:  code_d = MULHC;
        3'b010:  code_d = MULHSUC;
        3'b011:  code_d = MULHUC;
        default: code_d = MULC;
      endcase
    end else begin
      rd_d = rd_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      m_q        <= '0;
      q_q        <= '0;
      um_q       <= '0;
      uq_q       <= '0;
      code_q     <= 2'b00;
      ill_q      <= 1'b0;
      rd_q       <= '0;
      out_data_q <= '0;
      out_rd_q   <= '0;
      out_ill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_q        <= m_d;
      q_q        <= q_d;
      um_q       <= um_d;
      uq_q       <= uq_d;
      code_q     <= code_d;
      ill_q      <= ill_d;
      rd_q       <= rd_d;
      out_data_q <= out_data_d;
      out_rd_q   <= out_rd_d;
      out_ill_q  <= out_ill_d;
    end
  end

  assign mul_M       = m_q;
  assign mul_Q       = q_q;
  assign mul_UM      = um_q;
  assign mul_UQ      = uq_q;
  assign mul_code    = code_q;
  assign out_valid   = (state_q == S_DONE);
  assign out_data    = out_data_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_ill_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_issue_wb.sv
// Scoreboard bench for mul_issue_wb: one instance with LAT=1, one with LAT=3.
module tb_mul_issue_wb;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             nreset;
  logic [1:0]       in_valid, in_ready, out_valid, out_ready, out_ill, busy;
  logic [2:0]       funct3;
  logic [31:0]      rs1, rs2;
  logic [4:0]       rd;
  logic [1:0][31:0] mul_m, mul_q, mul_um, mul_uq, mul_res, out_data;
  logic [1:0][1:0]  mul_code;
  logic [1:0][4:0]  out_rd;

  exp_t q0[$];
  exp_t q1[$];
  int   hs_t[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

`ifdef MUL_B2B_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Environment model of the combinational multiplier, driven from the port routing.
  function automatic logic [31:0] mul_model(input logic [1:0] c, input logic [31:0] m, q, um, uq);
    logic [63:0] p;
    case (c)
      2'b00:   begin p = sx(m) * sx(q);           return p[31:0];  end
      2'b01:   begin p = sx(m) * sx(q);           return p[63:32]; end
      2'b10:   begin p = sx(q) * {32'd0, um};     return p[63:32]; end
      default: begin p = {32'd0, um} * {32'd0, uq}; return p[63:32]; end
    endcase
  endfunction

  // Architectural reference result for an RV32M op on rs1/rs2.
  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, b);
    logic signed [63:0] s;
    logic [63:0]        u;
    case (f)
      3'b000:  begin s = $signed(sx(a)) * $signed(sx(b)); return s[31:0]; end
      3'b001:  begin s = $signed(sx(a)) * $signed(sx(b)); return s[63:32]; end
      3'b010:  begin s = $signed(sx(a)) * $signed({32'd0, b}); return s[63:32]; end
      3'b011:  begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mul_issue_wb #(.dataW(32), .LAT((g == 0) ? 1 : 3), .RDW(5)) u_dut (
      .clk(clk), .nReset(nreset),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
      .mul_M(mul_m[g]), .mul_Q(mul_q[g]), .mul_UM(mul_um[g]), .mul_UQ(mul_uq[g]),
      .mul_code(mul_code[g]), .mul_result(mul_res[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_data(out_data[g]), .out_rd(out_rd[g]), .out_illegal(out_ill[g]),
      .busy(busy[g])
    );
    assign mul_res[g] = mul_model(mul_code[g], mul_m[g], mul_q[g], mul_um[g], mul_uq[g]);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop and compare on each result handshake.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (nreset && out_valid[i] && out_ready[i]) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("out_data", {32'd0, out_data[i]}, {32'd0, e.d});
          chk("out_rd", {59'd0, out_rd[i]}, {59'd0, e.rd});
          chk("out_illegal", {63'd0, out_ill[i]}, {63'd0, e.ill});
          if (i == 0) hs_t.push_back(cyc);
        end
      end
    end
  end

  // Offer an op to instance idx; returns 1 ns after the accepting edge.
  task automatic send(input int idx, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    exp_t e;
    int   n;
    e.d = ref_mul(f, a, b);
    e.rd = tag;
    e.ill = f[2];
    if (idx == 0) q0.push_back(e); else q1.push_back(e);
    in_valid[idx] = 1'b1;
    funct3 = f;
    rs1 = a;
    rs2 = b;
    rd = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_valid(input int idx, input int lat);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!out_valid[idx] && k < 20);
    chk("latency", 64'(k), 64'(lat));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drained", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    logic [2:0] rf;
    nreset = 1'b0;
    in_valid = 2'b11;
    out_ready = 2'b00;
    funct3 = 3'd0;
    rs1 = 32'd0;
    rs2 = 32'd0;
    rd = 5'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("rst_in_ready", {63'd0, in_ready[i]}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid[i]}, 64'd0);
        chk("rst_out_data", {32'd0, out_data[i]}, 64'd0);
        chk("rst_busy", {63'd0, busy[i]}, 64'd0);
      end
    end
    in_valid = 2'b00;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    #1;
    chk("rel_in_ready", {62'd0, in_ready}, 64'd3);
    out_ready = 2'b11;

    send(0, 3'b000, 32'd7, 32'd6, 5'd5);
    chk("code_mul", {62'd0, mul_code[0]}, 64'd0);
    wait_valid(0, 1);
    chk("mul_value", {32'd0, out_data[0]}, 64'h2A);
    send(0, 3'b001, 32'hFFFF_FFFE, 32'd3, 5'd6);
    chk("code_mulh", {62'd0, mul_code[0]}, 64'd1);
    wait_valid(0, 1);
    chk("mulh_value", {32'd0, out_data[0]}, 64'hFFFF_FFFF);
    send(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    chk("code_mulhu", {62'd0, mul_code[0]}, 64'd3);
    wait_valid(0, 1);
    chk("mulhu_value", {32'd0, out_data[0]}, 64'hFFFF_FFFE);
    send(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    chk("code_mulhsu", {62'd0, mul_code[0]}, 64'd2);
    chk("mulhsu_Q", {32'd0, mul_q[0]}, 64'hFFFF_FFFF);
    chk("mulhsu_UM", {32'd0, mul_um[0]}, 64'hFFFF_FFFF);
    wait_valid(0, 1);
    chk("mulhsu_value", {32'd0, out_data[0]}, 64'hFFFF_FFFF);
    send(0, 3'b010, 32'h8000_0000, 32'd3, 5'd9);
    chk("mulhsu_M", {32'd0, mul_m[0]}, 64'h8000_0000);
    chk("mulhsu_Q2", {32'd0, mul_q[0]}, 64'h8000_0000);
    chk("mulhsu_UM2", {32'd0, mul_um[0]}, 64'd3);
    chk("mulhsu_UQ2", {32'd0, mul_uq[0]}, 64'd3);
    wait_valid(0, 1);
    send(0, 3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10);
    chk("mul_Q", {32'd0, mul_q[0]}, 64'h9ABC_DEF0);
    chk("mul_UM", {32'd0, mul_um[0]}, 64'h1234_5678);
    wait_valid(0, 1);
    send(0, 3'b100, 32'd5, 32'd6, 5'd11);
    chk("code_illegal", {62'd0, mul_code[0]}, 64'd0);
    wait_valid(0, 1);
    chk("illegal_flag", {63'd0, out_ill[0]}, 64'd1);
    chk("illegal_data", {32'd0, out_data[0]}, 64'd0);
    send(1, 3'b111, 32'd9, 32'd9, 5'd12);
    wait_valid(1, 3);

    for (int r = 0; r < 10; r++) begin
      rf = 3'($urandom_range(0, 4));
      send(r % 2, rf, $urandom, $urandom, 5'(r + 13));
      wait_valid(r % 2, (r % 2 == 0) ? 1 : 3);
    end
    drain();

    // Backpressure on the LAT=3 instance.
    out_ready[1] = 1'b0;
    send(1, 3'b000, 32'd1000, 32'd3, 5'd27);
    wait_valid(1, 3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {63'd0, out_valid[1]}, 64'd1);
      chk("bp_data", {32'd0, out_data[1]}, 64'd3000);
      chk("bp_rd", {59'd0, out_rd[1]}, 64'd27);
      chk("bp_in_ready", {63'd0, in_ready[1]}, 64'd0);
    end
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_released", {62'd0, busy[1], out_valid[1]}, 64'd0);

    // Reset while the LAT=3 instance is mid-calculation drops the op.
    send(1, 3'b000, 32'd3, 32'd4, 5'd7);
    @(posedge clk);
    #1;
    chk("mid_busy", {63'd0, busy[1]}, 64'd1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy[1]}, 64'd0);
    chk("mid_rst_valid", {63'd0, out_valid[1]}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready[1]}, 64'd0);
    q1.delete();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("post_rst_valid", {63'd0, out_valid[1]}, 64'd0);
    end
    send(1, 3'b011, 32'hFFFF_FFFF, 32'd2, 5'd3);
    wait_valid(1, 3);
    drain();

    // Stream of four ops on the LAT=1 instance.
    hs_t.delete();
    for (int s = 0; s < 4; s++) send(0, 3'b000, 32'(s + 2), 32'd11, 5'(20 + s));
    drain();
    chk("stream_count", 64'(hs_t.size()), 64'd4);
    for (int s = 1; s < hs_t.size(); s++) chk("stream_gap", 64'(hs_t[s] - hs_t[s-1]), 64'(GAP));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_issue_wb.md
Name: mul_issue_wb

Overview:
- Sequential control stage around the combinational RV32M multiplier; sits directly upstream and downstream of it.
- Accepts a decoded M-extension multiply op (funct3, rs1, rs2, rd) through a valid/ready handshake.
- Registers the operands and drives the multiplier's M/Q/UM/UQ/mulCode inputs.
- Waits a fixed settle time (multicycle path), captures the product, and presents it with its rd tag to writeback through a second valid/ready handshake.

Parameters:
- dataW, 32, operand/result width.
- LAT, 1, multiplier settle cycles before capture (legal range 1..15).
- RDW, 5, destination register tag width.

Ports:
- clk  input  1  clock, rising-edge.
- nReset  input  1  asynchronous, active-low reset.
- in_valid  input  1  op offered.
- in_ready  output  1  stage can accept an op.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx illegal here.
- rs1  input  dataW  first source operand.
- rs2  input  dataW  second source operand.
- rd  input  RDW  destination tag.
- mul_M  output  dataW  signed multiplier operand to multiplier.
- mul_Q  output  dataW  signed multiplicand operand to multiplier.
- mul_UM  output  dataW  unsigned operand to multiplier.
- mul_UQ  output  dataW  unsigned operand to multiplier.
- mul_code  output  2  mulCode to multiplier (MULC/MULHC/MULHSUC/MULHUC from mul_codes.sv).
- mul_result  input  dataW  multiplier out.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts result.
- out_data  output  dataW  captured result.
- out_rd  output  RDW  tag of the result.
- out_illegal  output  1  op had funct3[2]=1.
- busy  output  1  state != IDLE.

Behaviour:
- Clock/reset: single clock clk. nReset is asynchronous and active-low.
- Reset values: state=IDLE; operand/code/rd/out registers = 0; out_valid=0; out_illegal=0; busy=0. in_ready = (state==IDLE) && nReset, so it is 0 while reset is asserted.
- Reset mid-operation: any in-flight op is dropped with no output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&&in_ready at an edge: latch rs1, rs2, rd and funct3; load cnt=LAT-1; go to CALC.
- CALC:
  - Operand registers are held stable.
  - cnt decrements each edge.
  - At the edge where cnt==0: out_data<=mul_result (forced 0 if illegal); out_rd<=latched rd; go to DONE.
- DONE:
  - out_valid=1; out_data, out_rd and out_illegal are held.
  - out_valid&&out_ready at an edge: go to IDLE.
  - out_valid must not drop, and data must not change, until the handshake completes.
- Latency: out_valid rises LAT edges after the accepting edge. With LAT=1, accept at E0 and out_valid is high after E1.
- Operand mapping (from registers, not from live inputs):
  - mul_M=rs1; mul_UQ=rs2.
  - MULHSU: mul_Q=rs1, mul_UM=rs2, so the multiplier's UM*Q gives signed rs1 × unsigned rs2.
  - All other ops: mul_Q=rs2, mul_UM=rs1.
  - mul_code: 000→MULC, 001→MULHC, 010→MULHSUC, 011→MULHUC.
- Illegal funct3 (1xx): the op is accepted and follows the normal timing. out_data=0, out_illegal=1. mul_code is driven as MULC.
- Width rule: out_data is exactly dataW bits. The high/low half selection is done by the multiplier.
- Inputs in_valid/funct3/rs1/rs2/rd are ignored when in_ready=0.
- out_ready asserted outside DONE has no effect.
- Simultaneous events: without the optional feature, a new op cannot be accepted in the same cycle a result handshakes. Peak throughput is one op per LAT+2 cycles.

Optional Feature:
- Macro MUL_B2B_EN.
- When defined:
  - in_ready = nReset && (state==IDLE || (state==DONE && out_ready)).
  - A new op accepted in DONE (result handshake in the same edge) latches operands and goes straight to CALC.
  - Throughput becomes one op per LAT+1 cycles.
  - in_ready then has a combinational path from out_ready.
- When undefined: in_ready depends on state only, with behaviour as above.

Test Plan:
- Reset: hold nReset=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, out_data=0. After release, in_ready=1.
- MUL, LAT=1: rs1=7, rs2=6, rd=5 → out_valid after 1 edge; out_data=0x0000002A, out_rd=5, mul_code=MULC.
- MULH: rs1=0xFFFFFFFE (-2), rs2=3 → out_data=0xFFFFFFFF.
- MULHU then MULHSU:
  - MULHU rs1=rs2=0xFFFFFFFF → out_data=0xFFFFFFFE.
  - MULHSU same operands → mul_Q=0xFFFFFFFF, mul_UM=0xFFFFFFFF; out_data=0xFFFFFFFF.
- Backpressure: LAT=3, out_ready=0 for 10 cycles → out_valid steady, out_data/out_rd stable, in_ready=0. out_ready=1 → IDLE next edge. Assert nReset=0 mid-CALC → IDLE, out_valid=0.
- Illegal, then back-to-back:
  - funct3=100 → out_illegal=1, out_data=0.
  - With MUL_B2B_EN, LAT=1, 4 ops streamed with out_ready=1 → results every 2 cycles, in order, tags intact.
